// File: rtl/mha_fixp_pkg.sv
// Shared fixed-point definitions for the multi-head attention datapath.
// Holds the default data/fraction widths, the 1.0 and max-positive
// constants, the fixed-point element type and the softmax normaliser
// state encoding.
package mha_fixp_pkg;

  localparam int D_W      = 16;
  localparam int FRAC_BIT = 13;

  localparam logic [D_W-1:0] FIXP_ONE = D_W'(1) << FRAC_BIT;
  localparam logic [D_W-1:0] FIXP_MAX = {1'b0, {(D_W-1){1'b1}}};

  typedef logic signed [D_W-1:0] fixp_t;

  typedef enum logic [0:0] {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } norm_state_e;

endpackage

// File: rtl/div_fast.sv
// Combinational fixed-point divider: quotient = (dividend << FRAC_BIT) / divisor,
// signed, truncated toward zero, narrowed back to D_W bits keeping the sign.
// Ports:
//   i_dividend  in  D_W  signed fixed-point numerator
//   i_divisor   in  D_W  signed fixed-point denominator
//   o_quotient  out D_W  signed fixed-point quotient
module div_fast #(
  parameter int D_W      = 16,
  parameter int FRAC_BIT = 13
) (
  input  logic [D_W-1:0] i_dividend,
  input  logic [D_W-1:0] i_divisor,
  output logic [D_W-1:0] o_quotient
);

  localparam int Q_W = D_W + FRAC_BIT;

  logic signed [Q_W-1:0] num_s;
  logic signed [Q_W-1:0] den_s;
  logic signed [Q_W-1:0] q_full_s;
  logic                  unused_q_bits_s;

  // Sign-extend, scale the numerator, divide; a zero divisor yields zero
  // so the output is always defined.
  always_comb begin
    num_s = {{FRAC_BIT{i_dividend[D_W-1]}}, i_dividend} <<< FRAC_BIT;
    den_s = {{FRAC_BIT{i_divisor[D_W-1]}}, i_divisor};
    if (den_s == '0) begin
      q_full_s = '0;
    end else begin
      q_full_s = num_s / den_s;
    end
    o_quotient = {q_full_s[Q_W-1], q_full_s[D_W-2:0]};
  end

  // The middle quotient bits are intentionally dropped by the narrowing.
  assign unused_q_bits_s = ^q_full_s[Q_W-2:D_W-1];

endmodule

// File: rtl/softmax_norm_seq.sv
// Softmax normalisation stage: buffers one row of non-negative exponent
// values while accumulating their saturating sum, then streams each
// buffered element through div_fast to emit exp_i / sum in input order.
// Ports:
//   I_CLK, I_RST_N     clock (rising) and async active-low reset
//   I_VALID/O_READY    upstream element handshake, I_DATA element
//   O_VALID/I_READY    downstream handshake, O_DATA normalised value
//   O_LAST             final element of the row (qualified by O_VALID)
//   O_SAT              row sum saturated, stable through the drain
module softmax_norm_seq
  import mha_fixp_pkg::*;
#(
  parameter int D_W      = mha_fixp_pkg::D_W,
  parameter int FRAC_BIT = mha_fixp_pkg::FRAC_BIT,
  parameter int ROW_LEN  = 8
) (
  input  logic           I_CLK,
  input  logic           I_RST_N,
  input  logic           I_VALID,
  output logic           O_READY,
  input  logic [D_W-1:0] I_DATA,
  output logic           O_VALID,
  input  logic           I_READY,
  output logic [D_W-1:0] O_DATA,
  output logic           O_LAST,
  output logic           O_SAT
);

  localparam int               PTR_W    = $clog2(ROW_LEN);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(ROW_LEN - 1);
  localparam logic [D_W-1:0]   SUM_MAX  = {1'b0, {(D_W-1){1'b1}}};

  norm_state_e      state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [D_W-1:0]   sum_q, sum_d;
  logic             sat_q, sat_d;
  logic [D_W-1:0]   buf_q [ROW_LEN];
  logic [D_W-1:0]   buf_d [ROW_LEN];
  logic             o_valid_q, o_valid_d;
  logic [D_W-1:0]   o_data_q, o_data_d;
  logic             o_last_q, o_last_d;

  logic             accept_s;
  logic             load_s;
  logic             done_s;
  logic [D_W-1:0]   clamp_s;
  logic [D_W:0]     sum_ext_s;
  logic [D_W-1:0]   quot_s;

  div_fast #(
    .D_W      (D_W),
    .FRAC_BIT (FRAC_BIT)
  ) u_div (
    .i_dividend (buf_q[rd_ptr_q]),
    .i_divisor  (sum_q),
    .o_quotient (quot_s)
  );

  // Next-state, datapath and handshake decode for the LOAD/DRAIN sequencer.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    sum_d     = sum_q;
    sat_d     = sat_q;
    buf_d     = buf_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_last_d  = o_last_q;

    accept_s  = (state_q == LOAD) && I_VALID;
    clamp_s   = I_DATA[D_W-1] ? '0 : I_DATA;
    sum_ext_s = {1'b0, sum_q} + {1'b0, clamp_s};
    // A pending last element means the row is exhausted: no further loads.
    load_s    = (state_q == DRAIN) && (!o_valid_q || I_READY) && !(o_valid_q && o_last_q);
    done_s    = (state_q == DRAIN) && o_valid_q && o_last_q && I_READY;

    case (state_q)
      LOAD: begin
        if (accept_s) begin
          buf_d[wr_ptr_q] = clamp_s;
          if (sum_ext_s > {1'b0, SUM_MAX}) begin
            sum_d = SUM_MAX;
            sat_d = 1'b1;
          end else begin
            sum_d = sum_ext_s[D_W-1:0];
          end
          if (wr_ptr_q == LAST_IDX) begin
            wr_ptr_d = '0;
            state_d  = DRAIN;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
      end
      DRAIN: begin
        if (load_s) begin
          // An all-zero row gives a zero sum; bypass the divider entirely.
          o_data_d  = (sum_q == '0) ? '0 : quot_s;
          o_last_d  = (rd_ptr_q == LAST_IDX);
          o_valid_d = 1'b1;
          rd_ptr_d  = rd_ptr_q + PTR_W'(1);
        end else if (done_s) begin
          o_valid_d = 1'b0;
          o_last_d  = 1'b0;
          state_d   = LOAD;
          sum_d     = '0;
          sat_d     = 1'b0;
          rd_ptr_d  = '0;
        end else begin
          o_valid_d = o_valid_q;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q   <= LOAD;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      sum_q     <= '0;
      sat_q     <= 1'b0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_last_q  <= 1'b0;
      for (int i = 0; i < ROW_LEN; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      sum_q     <= sum_d;
      sat_q     <= sat_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_last_q  <= o_last_d;
      buf_q     <= buf_d;
    end
  end

  assign O_READY = (state_q == LOAD);
  assign O_VALID = o_valid_q;
  assign O_DATA  = o_data_q;
  assign O_LAST  = o_last_q;
  assign O_SAT   = sat_q;

endmodule

// File: tb/tb_softmax_norm_seq.sv
// Directed self-checking bench for softmax_norm_seq (ROW_LEN=8, Q2.13).
module tb_softmax_norm_seq;

  logic        I_CLK = 1'b0;
  logic        I_RST_N;
  logic        I_VALID;
  logic        O_READY;
  logic [15:0] I_DATA;
  logic        O_VALID;
  logic        I_READY;
  logic [15:0] O_DATA;
  logic        O_LAST;
  logic        O_SAT;

  int n_vec = 0;
  int n_bad = 0;

  logic [15:0] row_in  [8];
  logic [15:0] exp_out [8];

  softmax_norm_seq #(.D_W(16), .FRAC_BIT(13), .ROW_LEN(8)) dut (
    .I_CLK   (I_CLK),
    .I_RST_N (I_RST_N),
    .I_VALID (I_VALID),
    .O_READY (O_READY),
    .I_DATA  (I_DATA),
    .O_VALID (O_VALID),
    .I_READY (I_READY),
    .O_DATA  (O_DATA),
    .O_LAST  (O_LAST),
    .O_SAT   (O_SAT)
  );

  always #5 I_CLK = ~I_CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Feed row_in; returns at the falling edge after the 8th accept.
  task automatic push_row();
    for (int i = 0; i < 8; i++) begin
      @(negedge I_CLK);
      I_VALID = 1'b1;
      I_DATA  = row_in[i];
      check("o_ready_load", 32'(O_READY), 32'd1);
      @(posedge I_CLK);
    end
    @(negedge I_CLK);
    I_VALID = 1'b0;
    I_DATA  = 16'h1234;
    check("drain_entry_no_valid", 32'(O_VALID), 32'd0);
    check("drain_o_ready_low", 32'(O_READY), 32'd0);
  endtask

  // Collect n_take outputs against exp_out, optionally stalling at one index.
  task automatic drain(input logic exp_sat, input int n_take, input int stall_at, input int stall_len);
    int idx;
    int stalled;
    int cyc;
    bit first;
    idx = 0; stalled = 0; cyc = 0; first = 1'b1;
    while (idx < n_take && cyc < 64) begin
      @(negedge I_CLK);
      cyc++;
      if (first) begin
        check("first_valid_latency", 32'(O_VALID), 32'd1);
        first = 1'b0;
      end
      if (idx == stall_at && stalled < stall_len) begin
        I_READY = 1'b0;
        stalled++;
        check("stall_valid", 32'(O_VALID), 32'd1);
        check("stall_data", 32'(O_DATA), 32'(exp_out[idx]));
        check("stall_last", 32'(O_LAST), 32'(idx == 7));
        check("stall_o_ready", 32'(O_READY), 32'd0);
      end else begin
        I_READY = 1'b1;
        if (O_VALID) begin
          check("out_data", 32'(O_DATA), 32'(exp_out[idx]));
          check("out_last", 32'(O_LAST), 32'(idx == 7));
          check("out_sat", 32'(O_SAT), 32'(exp_sat));
          check("out_o_ready", 32'(O_READY), 32'd0);
          idx++;
        end
      end
    end
    check("drain_count", 32'(idx), 32'(n_take));
    if (n_take == 8) begin
      @(negedge I_CLK);
      check("row_end_valid", 32'(O_VALID), 32'd0);
      check("row_end_o_ready", 32'(O_READY), 32'd1);
      check("row_end_sat", 32'(O_SAT), 32'd0);
    end
  endtask

  initial begin
    I_RST_N = 1'b0;
    I_VALID = 1'b0;
    I_DATA  = 16'h0000;
    I_READY = 1'b0;
    repeat (2) @(negedge I_CLK);
    check("rst_valid", 32'(O_VALID), 32'd0);
    check("rst_data", 32'(O_DATA), 32'd0);
    check("rst_last", 32'(O_LAST), 32'd0);
    check("rst_sat", 32'(O_SAT), 32'd0);
    check("rst_o_ready", 32'(O_READY), 32'd1);
    I_RST_N = 1'b1;

    // 8 x 1/8 -> sum 1.0, each output 1/8
    for (int i = 0; i < 8; i++) begin row_in[i] = 16'h0400; exp_out[i] = 16'h0400; end
    push_row();
    drain(1'b0, 8, -1, 0);

    // one-hot 1.0 -> 1.0 then zeros
    for (int i = 0; i < 8; i++) begin row_in[i] = 16'h0000; exp_out[i] = 16'h0000; end
    row_in[0] = 16'h2000; exp_out[0] = 16'h2000;
    push_row();
    drain(1'b0, 8, -1, 0);

    // negative clamps to 0, all-zero row -> sum 0, outputs 0
    for (int i = 0; i < 8; i++) begin row_in[i] = 16'h0000; exp_out[i] = 16'h0000; end
    row_in[0] = 16'hF000;
    push_row();
    drain(1'b0, 8, -1, 0);

    // negative clamped alongside a positive: sum 0x0400
    for (int i = 0; i < 8; i++) begin row_in[i] = 16'h0000; exp_out[i] = 16'h0000; end
    row_in[0] = 16'hF000;
    row_in[1] = 16'h0400; exp_out[1] = 16'h2000;
    push_row();
    drain(1'b0, 8, -1, 0);

    // 8 x 1.0 -> sum saturates at 0x7FFF, each output 0x0800
    for (int i = 0; i < 8; i++) begin row_in[i] = 16'h2000; exp_out[i] = 16'h0800; end
    push_row();
    drain(1'b1, 8, -1, 0);

    // back-pressure: sum 0x1400, stall 3 cycles after the 2nd output
    for (int i = 0; i < 8; i++) row_in[i] = 16'((i % 4 + 1) * 256);
    for (int i = 0; i < 8; i += 4) begin
      exp_out[i]   = 16'h0199;
      exp_out[i+1] = 16'h0333;
      exp_out[i+2] = 16'h04CC;
      exp_out[i+3] = 16'h0666;
    end
    push_row();
    drain(1'b0, 8, 2, 3);

    // reset mid-drain after the 4th output
    for (int i = 0; i < 8; i++) begin row_in[i] = 16'h0400; exp_out[i] = 16'h0400; end
    push_row();
    drain(1'b0, 4, -1, 0);
    @(negedge I_CLK);
    I_RST_N = 1'b0;
    #1;
    check("midrst_valid", 32'(O_VALID), 32'd0);
    check("midrst_data", 32'(O_DATA), 32'd0);
    check("midrst_last", 32'(O_LAST), 32'd0);
    check("midrst_o_ready", 32'(O_READY), 32'd1);
    @(negedge I_CLK);
    I_RST_N = 1'b1;
    I_READY = 1'b0;
    push_row();
    drain(1'b0, 8, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
